// File: rtl/cle361_wr.sv
// cle361_wr: memory-mapped serial write port.
//
// A single-entry holding register accepts bytes from the host bus and feeds
// a UART-style transmitter. Each frame is one start bit (0), eight data bits
// LSB first, an optional odd-parity bit, and one stop bit (1). Every bit
// lasts DIV clock cycles. The transmitter runs back-to-back when another
// byte is waiting at the end of a stop bit.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   sser_n   serial-port select, active low
//   ba13     window decode, must be 0
//   ba12     window decode, must be 1
//   ba7_4    register select: 0 = data, 1 = control/status
//   br_w     bus direction: 1 = read, 0 = write
//   bd       bus write data
//   sdwr     serial data out, idle high
//   busy     high while a frame is being sent
//   rd_data  status {5'b0, ovr, hold_full, busy} when rd_oe, else 0
//   rd_oe    high during a status read
module cle361_wr #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sser_n,
  input  logic       ba13,
  input  logic       ba12,
  input  logic [3:0] ba7_4,
  input  logic       br_w,
  input  logic [7:0] bd,
  output logic       sdwr,
  output logic       busy,
  output logic [7:0] rd_data,
  output logic       rd_oe
);

  localparam logic [7:0] DivLast = 8'(DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e     state_q;
  logic [7:0] div_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       par_q;      // parity enable latched for the frame in flight
  logic       par_bit_q;  // odd-parity bit of the frame in flight
  logic       sdwr_q;
  logic       busy_q;

  logic [7:0] hold_q;
  logic       hold_full_q;
  logic       ovr_q;
  logic       par_en_q;
  logic       wr_q;

  logic acc, wr, rd, wr_edge, data_wr, ctrl_wr;
  logic bit_end, tx_load, ovr_set, ovr_clr;

  // Bus decode and write-edge detection.
  always_comb begin
    acc     = ~sser_n & ~ba13 & ba12;
    wr      = acc & ~br_w;
    rd      = acc & br_w;
    wr_edge = wr & ~wr_q;
    data_wr = wr_edge & (ba7_4 == 4'd0);
    ctrl_wr = wr_edge & (ba7_4 == 4'd1);
  end

  // The transmitter takes the holding byte from IDLE, or at the end of a
  // stop bit so consecutive frames abut with no idle gap.
  always_comb begin
    bit_end = (div_q == 8'd0);
    tx_load = hold_full_q & ((state_q == StIdle) | ((state_q == StStop) & bit_end));
    ovr_set = data_wr & hold_full_q & ~tx_load;
    ovr_clr = ctrl_wr & bd[1];
  end

  // Host-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      ovr_q       <= 1'b0;
      par_en_q    <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      wr_q <= wr;
      // A write landing on the transfer edge refills the slot being emptied.
      if (data_wr && (!hold_full_q || tx_load)) begin
        hold_q      <= bd;
        hold_full_q <= 1'b1;
      end else if (tx_load) begin
        hold_full_q <= 1'b0;
      end
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr) begin
        ovr_q <= 1'b0;
      end
      if (ctrl_wr) begin
        par_en_q <= bd[0];
      end
    end
  end

  // Transmit FSM with registered sdwr/busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      div_q     <= 8'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      par_bit_q <= 1'b0;
      sdwr_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else if (tx_load) begin
      shift_q   <= hold_q;
      par_bit_q <= ~^hold_q;
      par_q     <= par_en_q;
      div_q     <= DivLast;
      bit_q     <= 3'd0;
      state_q   <= StStart;
      sdwr_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      if (state_q != StIdle) begin
        div_q <= bit_end ? DivLast : div_q - 8'd1;
      end
      unique case (state_q)
        StIdle: begin
          sdwr_q <= 1'b1;
          busy_q <= 1'b0;
        end
        StStart: begin
          if (bit_end) begin
            state_q <= StData;
            bit_q   <= 3'd0;
            sdwr_q  <= shift_q[0];
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              state_q <= par_q ? StParity : StStop;
              sdwr_q  <= par_q ? par_bit_q : 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              sdwr_q  <= shift_q[1];
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            state_q <= StStop;
            sdwr_q  <= 1'b1;
          end
        end
        StStop: begin
          // Reload with a waiting byte is handled by tx_load above.
          if (bit_end) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            sdwr_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          sdwr_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sdwr    = sdwr_q;
  assign busy    = busy_q;
  assign rd_oe   = rd & (ba7_4 == 4'd1);
  assign rd_data = rd_oe ? {5'b00000, ovr_q, hold_full_q, busy_q} : 8'h00;

endmodule

// File: doc/cle361_wr.md
CLE361_WR -- requirements
Module: cle361_wr

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning clock cycles per serial bit (legal 2..255).
REQ-002 SHALL have ports clk, rst_n first; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 sser_n  input  1  serial-port select, active low.
REQ-006 ba13, ba12  input  1 each  window decode; block selected when ba13=0, ba12=1.
REQ-007 ba7_4  input  4  register select: 0=data, 1=control/status.
REQ-008 br_w  input  1  bus direction: 1=read, 0=write.
REQ-009 bd  input  8  bus write data.
REQ-010 sdwr  output  1  serial data out; idle high.
REQ-011 busy  output  1  high while a frame is on sdwr.
REQ-012 rd_data  output  8  status read data.
REQ-013 rd_oe  output  1  high when rd_data is valid to drive the bus.

Function
REQ-014 Access SHALL be qualified as acc = ~sser_n & ~ba13 & ba12; wr = acc & ~br_w; rd = acc & br_w.
REQ-015 A write SHALL take effect once per assertion, on the first rising edge where wr is high (previous-cycle wr low); held wr SHALL not repeat it.
REQ-016 Data write (ba7_4=0) with holding empty SHALL load bd into holding register; hold_full=1 from the next cycle.
REQ-017 Data write with holding full SHALL drop bd and set sticky ovr.
REQ-018 Control write (ba7_4=1): bd[0] sets par_en (odd parity), bd[1]=1 clears ovr; other bits ignored.
REQ-019 Same-edge set and clear of ovr SHALL leave ovr=1 (set wins).
REQ-020 Writes to ba7_4 values other than 0,1 SHALL be ignored.
REQ-021 rd_oe = rd & (ba7_4==1); rd_data = {5'b0, ovr, hold_full, busy} when rd_oe, else 8'h00; combinational.
REQ-022 Transmit FSM states IDLE, START, DATA, PARITY, STOP.
REQ-023 IDLE with hold_full=1: next edge loads shifter from holding, latches par_en, clears hold_full, enters START; sdwr=0 from that edge.
REQ-024 Each bit state SHALL last exactly DIV cycles, timed by an 8-bit divider counter reloaded at every bit boundary.
REQ-025 DATA SHALL send 8 bits LSB first, counted by a 3-bit bit counter; after bit 7 go to PARITY if latched par_en else STOP.
REQ-026 PARITY bit SHALL be odd parity: ~^(shifted byte).
REQ-027 STOP SHALL drive sdwr=1 for DIV cycles, then: hold_full=1 -> load and enter START on same boundary edge (back-to-back, no idle gap); else IDLE.
REQ-028 Frame length SHALL be 10*DIV cycles (par_en=0) or 11*DIV (par_en=1).
REQ-029 busy SHALL be 1 in START, DATA, PARITY, STOP; 0 in IDLE.
REQ-030 Data write on the same edge the holding register transfers to the shifter SHALL be accepted without overrun.
REQ-031 par_en changes mid-frame SHALL affect only frames loaded afterwards.

Reset
REQ-032 rst_n low SHALL immediately force: state IDLE, sdwr=1, busy=0, hold_full=0, ovr=0, par_en=0, counters 0, write-edge detector 0.
REQ-033 Reset mid-frame SHALL abort the frame with no partial completion; first write after release starts a fresh frame.

Verification (DIV=4 unless stated)
REQ-034 Write 8'hA5 to data, par_en=0 -> sdwr 0,1,0,1,0,0,1,0,1,1 each 4 cycles (40 total), busy high 40 cycles.
REQ-035 Control write 8'h01, then data 8'h03 -> parity bit 1 (odd), frame 44 cycles.
REQ-036 Write 8'h11, then 8'h22 during frame, then 8'h33 while holding full -> frames 11h,22h back-to-back with no gap; 33h dropped; status read = 8'h04 after both frames.
REQ-037 wr held low-active (sser_n=0, br_w=0) for 10 cycles with 8'h55 -> exactly one frame sent, ovr=0.
REQ-038 Assert rst_n low in DATA bit 3 -> sdwr=1, busy=0 same cycle; status read returns 8'h00.
REQ-039 DIV=2, write 8'hFF -> frame of 20 cycles; control write 8'h02 with simultaneous overrun-causing write -> ovr stays 1.
